// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, active/sync decode and pipeline-aligned sync outputs
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIPE_DLY = 2
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic       vblank_start,
  output logic [7:0] frame_cnt
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  if (H_TOTAL > 1024 || V_TOTAL > 1024 || PIPE_DLY < 0 || PIPE_DLY > 4) begin : g_bad_params
    $error("vga_timing_gen: totals must fit 10-bit counters and PIPE_DLY must be 0..4");
  end
  logic [9:0] h_nxt, v_nxt;
  logic [PIPE_DLY:0] hs_sr, vs_sr;
  // next raster position; vertical advances only when the line wraps
  always_comb begin
    h_nxt = (DrawX == H_LAST) ? '0 : DrawX + 10'd1;
    v_nxt = (DrawX != H_LAST) ? DrawY : (DrawY == V_LAST) ? '0 : DrawY + 10'd1;
  end
  // decode from next-state so every flag lands in the same cycle as its DrawX/DrawY
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      DrawX        <= '0;
      DrawY        <= '0;
      blank        <= 1'b1;
      frame_start  <= 1'b1;
      vblank_start <= 1'b0;
      frame_cnt    <= '0;
      hs_sr        <= '1;
      vs_sr        <= '1;
    end else begin
      DrawX        <= h_nxt;
      DrawY        <= v_nxt;
      blank        <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
      frame_start  <= (h_nxt == '0) && (v_nxt == '0);
      vblank_start <= (h_nxt == '0) && (v_nxt == V_ACT);
      frame_cnt    <= frame_cnt + {7'd0, (DrawX == H_LAST) && (DrawY == V_LAST)};
      hs_sr[0]     <= !((h_nxt >= HS_BEG) && (h_nxt <= HS_END));
      vs_sr[0]     <= !((v_nxt >= VS_BEG) && (v_nxt <= VS_END));
      for (int i = 1; i <= PIPE_DLY; i++) begin
        hs_sr[i] <= hs_sr[i-1];
        vs_sr[i] <= vs_sr[i-1];
      end
    end
  end
  assign hs = hs_sr[PIPE_DLY];
  assign vs = vs_sr[PIPE_DLY];
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator that drives the pixel pipeline's DrawX/DrawY/blank inputs and the monitor's hs/vs pins. It free-runs a horizontal and vertical counter at the pixel clock, decodes the active region and sync pulses, and delays hs/vs by a configurable number of cycles so they line up with color data emerging from the sprite ROM/palette/output-register pipeline. It also supplies frame-level pulses and a frame counter for game-logic pacing.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 96, horizontal sync width (cycles)
- H_BP, 48, horizontal back porch (cycles)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- PIPE_DLY, 2, cycles hs/vs lag DrawX/DrawY; legal range 0..4

Ports:
- vga_clk  in  1  pixel clock; the single clock of the block; one pixel per cycle
- reset  in  1  synchronous, active-high reset
- DrawX  out  10  current horizontal count, 0..H_TOTAL-1 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800)
- DrawY  out  10  current vertical count, 0..V_TOTAL-1 (V_TOTAL = 525)
- blank  out  1  display enable, 1 = visible pixel (DrawX<H_ACTIVE and DrawY<V_ACTIVE), 0 = blanking
- hs  out  1  horizontal sync, active-low, delayed PIPE_DLY cycles
- vs  out  1  vertical sync, active-low, delayed PIPE_DLY cycles
- frame_start  out  1  high exactly when DrawX=0 and DrawY=0
- vblank_start  out  1  high exactly when DrawX=0 and DrawY=V_ACTIVE
- frame_cnt  out  8  frames completed since reset, wraps

## Operation
- All outputs are registers; no combinational path from counters to ports.
- Horizontal counter h: increments every cycle; at H_TOTAL-1 wraps to 0.
- Vertical counter v: increments only on the cycle h wraps; at V_TOTAL-1 (with h wrap) wraps to 0.
- DrawX=h, DrawY=v.
- blank, frame_start, vblank_start are computed from the next-state counter values and registered, so each is valid in the same cycle as the DrawX/DrawY it describes.
- Undelayed sync: hs_raw=0 for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = 656..751; vs_raw=0 for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = 490..491 (entire lines, switching at h=0); else 1.
- hs/vs pass through a PIPE_DLY-deep shift register of 1-bit stages; PIPE_DLY=0 makes hs/vs aligned with DrawX/DrawY.
- frame_cnt increments by 1 on the cycle (h,v) transitions from (H_TOTAL-1,V_TOTAL-1) to (0,0); 255 wraps to 0.
- Width rule: counters are 10 bits; parameter sums must satisfy H_TOTAL≤1024, V_TOTAL≤1024 (elaboration-time assertion).

## Timing
- Reset values (cycle reset is sampled high and while held): DrawX=0, DrawY=0, blank=1, hs=1, vs=1 (all delay stages filled with 1), frame_start=1, vblank_start=0, frame_cnt=0.
- First cycle after reset deasserts: DrawX=1, DrawY=0; counting continues from (0,0) with no skipped pixel.
- Reset asserted mid-frame: next edge forces all reset values; the delay line is flushed to 1, so no partial sync pulse is emitted afterward.
- Line period 800 cycles, frame period 420000 cycles; frame_start and vblank_start each 1 cycle wide, once per frame.
- hs falls PIPE_DLY cycles after the cycle DrawX=656 is presented; low for exactly 96 cycles.
- vs low for exactly 1600 cycles, falling PIPE_DLY cycles after (DrawX,DrawY)=(0,490).
- Simultaneous h and v wrap: single cycle, (799,524) -> (0,0), frame_start=1 and frame_cnt increment in that same output cycle.

## Test plan
- Reset then release, PIPE_DLY=2 -> DrawX sequence 0,1,2,...; frame_start=1 only at (0,0); hs=vs=1 for first 658 cycles.
- Run one full line -> blank=1 for DrawX 0..639, 0 for 640..799; hs low for cycles where DrawX was 656..751 shifted by 2; after (799,0) comes (0,1).
- Run one full frame -> 420000 cycles between frame_start pulses; vblank_start at (0,480); vs low for 1600 cycles; blank=0 for all of lines 480..524; frame_cnt 0->1 at second frame_start.
- PIPE_DLY=0 build -> hs=0 in exactly the cycles DrawX∈656..751; PIPE_DLY=4 -> same pulse shifted 4 cycles.
- Assert reset for one cycle at (700,491) with hs and vs low -> next cycle all reset values, hs=vs=1, frame_cnt=0; normal timing resumes.
- Run 256 frames -> frame_cnt reaches 255 then wraps to 0 on the 256th frame_start.
